// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the instruction encoder and decoder.
package isa_pkg;
    localparam int OPCODE_WIDTH  = 3;
    localparam int INSTR_WIDTH   = 16;
    localparam int REG_WIDTH     = 3;
    localparam int OPERAND_WIDTH = 7;
    localparam int OPC_LSB = 13;
    localparam int DST_LSB = 10;
    localparam int SRC_LSB = 7;
    localparam int OPR_LSB = 0;
    localparam logic [INSTR_WIDTH-1:0] WAIT_WORD = 16'h8000;
    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_MUL  = 3'd2,
        OP_MULI = 3'd3,
        OP_WAIT = 3'd4,
        OP_LDSW = 3'd5
    } opcode_e;
    function automatic logic [INSTR_WIDTH-1:0] pack_fields(
        input logic [OPCODE_WIDTH-1:0]  op,
        input logic [REG_WIDTH-1:0]     dst,
        input logic [REG_WIDTH-1:0]     src,
        input logic [OPERAND_WIDTH-1:0] opr
    );
        logic [INSTR_WIDTH-1:0] w;
        w = '0;
        w[OPC_LSB +: OPCODE_WIDTH]  = op;
        w[DST_LSB +: REG_WIDTH]     = dst;
        w[SRC_LSB +: REG_WIDTH]     = src;
        w[OPR_LSB +: OPERAND_WIDTH] = opr;
        return w;
    endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: field forcing, legality check and packing of one instruction beat.
module instr_pack
    import isa_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]  opcode_i,
    input  logic [REG_WIDTH-1:0]     dst_i,
    input  logic [REG_WIDTH-1:0]     src_i,
    input  logic [OPERAND_WIDTH-1:0] operand_i,
    output logic [INSTR_WIDTH-1:0]   word_o,
    output logic                     legal_o
);
    logic reg_form;
    always_comb begin
        reg_form = opcode_i == OP_ADD || opcode_i == OP_MUL;
        // register forms carry rt in operand[2:0]; upper bits must be clear
        legal_o  = opcode_i <= OP_LDSW && !(reg_form && operand_i[6:3] != '0);
        word_o   = opcode_i == OP_WAIT ? WAIT_WORD :
                   opcode_i == OP_LDSW ? pack_fields(opcode_i, dst_i, '0, '0) :
                                         pack_fields(opcode_i, dst_i, src_i, operand_i);
    end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs streamed instruction fields into program memory
// and seals the program with a terminating WAIT word.
module instruction_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     seal,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPCODE_WIDTH-1:0]  in_opcode,
    input  logic [REG_WIDTH-1:0]     in_dst,
    input  logic [REG_WIDTH-1:0]     in_src,
    input  logic [OPERAND_WIDTH-1:0] in_operand,
    output logic                     mem_we,
    output logic [ADDR_WIDTH-1:0]    mem_addr,
    output logic [INSTR_WIDTH-1:0]   mem_wdata,
    output logic [ADDR_WIDTH:0]      prog_len,
    output logic                     busy,
    output logic                     done,
    output logic                     err_illegal,
    output logic [7:0]               err_count
);
    typedef enum logic [1:0] {IDLE, LOAD, SEAL, DONE} state_e;
    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [INSTR_WIDTH-1:0]  mem_wdata_q;
    logic                    err_q;
    logic [7:0]              err_cnt_q;
    logic                    seal_wr_q;
    logic [INSTR_WIDTH-1:0]  word_d;
    logic                    legal_d;
    logic                    accept_d;
    instr_pack u_pack (
        .opcode_i  (in_opcode),
        .dst_i     (in_dst),
        .src_i     (in_src),
        .operand_i (in_operand),
        .word_o    (word_d),
        .legal_o   (legal_d)
    );
    // the last slot (all-ones address) stays free for the seal word
    assign in_ready    = state_q == LOAD && ptr_q != '1;
    assign accept_d    = in_valid && in_ready;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign prog_len    = len_q;
    assign busy        = state_q == LOAD || state_q == SEAL;
    assign done        = state_q == DONE;
    assign err_illegal = err_q;
    assign err_count   = err_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            seal_wr_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                        len_q   <= '0;
                    end
                end
                LOAD: begin
                    if (accept_d && legal_d) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= word_d;
                        ptr_q       <= ptr_q + 1'b1;
                        len_q       <= len_q + 1'b1;
                    end
                    if (accept_d && !legal_d) begin
                        err_q <= 1'b1;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    if (seal) state_q <= SEAL;
                end
                SEAL: begin
                    // first cycle issues the WAIT write, second lets it land before DONE
                    if (!seal_wr_q) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= WAIT_WORD;
                        len_q       <= len_q + 1'b1;
                        seal_wr_q   <= 1'b1;
                    end else begin
                        seal_wr_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and randomized checks of instruction_encoder
// against a field-arithmetic reference model.
module tb_instruction_encoder;
    localparam int AW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start, seal, in_valid, in_ready;
    logic [2:0] in_opcode, in_dst, in_src;
    logic [6:0] in_operand;
    logic mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [AW:0] prog_len;
    logic busy, done, err_illegal;
    logic [7:0] err_count;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    instruction_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .seal(seal),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_dst(in_dst), .in_src(in_src), .in_operand(in_operand),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .prog_len(prog_len), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_count(err_count)
    );
    // reference: word = opcode*2^13 + dst*2^10 + src*2^7 + operand, with forcing
    function automatic logic [15:0] exp_word(input int op, input int dst, input int src, input int opr);
        if (op == 4) return 16'(op * 8192);
        if (op == 5) return 16'(op * 8192 + dst * 1024);
        return 16'(op * 8192 + dst * 1024 + src * 128 + opr);
    endfunction
    function automatic bit exp_legal(input int op, input int opr);
        return op < 6 && !((op == 0 || op == 2) && opr > 7);
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle_in;
        start = 0; seal = 0; in_valid = 0;
        in_opcode = 0; in_dst = 0; in_src = 0; in_operand = 0;
    endtask
    task automatic beat(input int op, input int dst, input int src, input int opr);
        in_valid = 1; in_opcode = 3'(op); in_dst = 3'(dst); in_src = 3'(src); in_operand = 7'(opr);
    endtask
    task automatic do_reset;
        idle_in();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask
    task automatic begin_prog;
        start = 1;
        tick();
        start = 0;
    endtask
    task automatic test_reset;
        do_reset();
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, prog_len, busy, done, err_illegal, err_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%0d data=%h len=%0d busy=%b done=%b err=%b cnt=%0d, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, prog_len, busy, done, err_illegal, err_count);
        end
        seal = 1;
        beat(1, 1, 1, 1);
        tick();
        idle_in();
        total++;
        if ({mem_we, busy, done, in_ready} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_ignores: got we/busy/done/ready=%b, want 0000", {mem_we, busy, done, in_ready});
        end
    endtask
    task automatic test_encode;
        do_reset();
        begin_prog();
        total++;
        if ({in_ready, busy, done} !== 3'b110) begin
            bad++;
            $display("FAIL load_entry: got ready/busy/done=%b, want 110", {in_ready, busy, done});
        end
        beat(0, 1, 2, 3);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, mem_wdata, prog_len} !== {1'b1, 4'd0, 16'h0503, 5'd1}) begin
            bad++;
            $display("FAIL encode_add: got we=%b addr=%0d data=%h len=%0d, want we=1 addr=0 data=0503 len=1",
                     mem_we, mem_addr, mem_wdata, prog_len);
        end
    endtask
    task automatic test_forcing;
        do_reset();
        begin_prog();
        beat(1, 2, 2, 'h7F);
        tick();
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd0, 16'h297F}) begin
            bad++;
            $display("FAIL addi_pass: got we=%b addr=%0d data=%h, want 1/0/297f", mem_we, mem_addr, mem_wdata);
        end
        beat(4, 7, 5, 'h55);
        tick();
        total++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'd1, 16'h8000}) begin
            bad++;
            $display("FAIL wait_force: got we=%b addr=%0d data=%h, want 1/1/8000", mem_we, mem_addr, mem_wdata);
        end
        beat(5, 3, 4, 9);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, mem_wdata, prog_len} !== {1'b1, 4'd2, 16'hAC00, 5'd3}) begin
            bad++;
            $display("FAIL ldsw_force: got we=%b addr=%0d data=%h len=%0d, want 1/2/ac00/3",
                     mem_we, mem_addr, mem_wdata, prog_len);
        end
    endtask
    task automatic test_illegal;
        do_reset();
        begin_prog();
        beat(6, 1, 1, 1);
        tick();
        total++;
        if ({mem_we, err_illegal, err_count} !== {1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL illegal_op6: got we=%b err=%b cnt=%0d, want 0/1/1", mem_we, err_illegal, err_count);
        end
        beat(0, 1, 1, 8);
        tick();
        total++;
        if ({mem_we, err_illegal, err_count, prog_len} !== {1'b0, 1'b1, 8'd2, 5'd0}) begin
            bad++;
            $display("FAIL illegal_add_opr: got we=%b err=%b cnt=%0d len=%0d, want 0/1/2/0",
                     mem_we, err_illegal, err_count, prog_len);
        end
        beat(2, 4, 5, 7);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, mem_wdata, err_illegal, err_count} !== {1'b1, 4'd0, exp_word(2, 4, 5, 7), 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL after_illegal: got we=%b addr=%0d data=%h err=%b cnt=%0d, want 1/0/%h/0/2",
                     mem_we, mem_addr, mem_wdata, err_illegal, err_count, exp_word(2, 4, 5, 7));
        end
    endtask
    task automatic test_fill_seal;
        do_reset();
        begin_prog();
        for (int i = 0; i < 15; i++) begin
            int op, dst, src, opr;
            op = $urandom_range(5); dst = $urandom_range(7); src = $urandom_range(7);
            opr = (op == 0 || op == 2) ? $urandom_range(7) : $urandom_range(127);
            beat(op, dst, src, opr);
            tick();
            total++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 4'(i), exp_word(op, dst, src, opr)}) begin
                bad++;
                $display("FAIL fill_write[%0d]: got we=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, mem_we, mem_addr, mem_wdata, i, exp_word(op, dst, src, opr));
            end
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b, want 0", in_ready);
        end
        tick();
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL full_no_write: got we=%b, want 0", mem_we);
        end
        seal = 1;
        tick();
        seal = 0;
        tick();
        total++;
        if ({mem_we, mem_addr, mem_wdata, prog_len, done} !== {1'b1, 4'd15, 16'h8000, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL full_seal: got we=%b addr=%0d data=%h len=%0d done=%b, want 1/15/8000/16/0",
                     mem_we, mem_addr, mem_wdata, prog_len, done);
        end
        tick();
        tick();
        idle_in();
        total++;
        if ({mem_we, done, busy, in_ready, prog_len} !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd16}) begin
            bad++;
            $display("FAIL done_idle: got we=%b done=%b busy=%b ready=%b len=%0d, want 0/1/0/0/16",
                     mem_we, done, busy, in_ready, prog_len);
        end
    endtask
    task automatic test_back_to_back;
        do_reset();
        begin_prog();
        beat(3, 6, 1, 'h2A);
        seal = 1;
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, mem_wdata, done} !== {1'b1, 4'd0, exp_word(3, 6, 1, 'h2A), 1'b0}) begin
            bad++;
            $display("FAIL conc_data: got we=%b addr=%0d data=%h done=%b, want 1/0/%h/0",
                     mem_we, mem_addr, mem_wdata, done, exp_word(3, 6, 1, 'h2A));
        end
        tick();
        total++;
        if ({mem_we, mem_addr, mem_wdata, prog_len, done} !== {1'b1, 4'd1, 16'h8000, 5'd2, 1'b0}) begin
            bad++;
            $display("FAIL conc_seal: got we=%b addr=%0d data=%h len=%0d done=%b, want 1/1/8000/2/0",
                     mem_we, mem_addr, mem_wdata, prog_len, done);
        end
        tick();
        total++;
        if ({done, mem_we} !== 2'b10) begin
            bad++;
            $display("FAIL conc_done: got done/we=%b, want 10", {done, mem_we});
        end
        begin_prog();
        total++;
        if ({done, busy, in_ready, prog_len} !== {1'b0, 1'b1, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL restart: got done=%b busy=%b ready=%b len=%0d, want 0/1/1/0", done, busy, in_ready, prog_len);
        end
        beat(1, 0, 0, 5);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, prog_len} !== {1'b1, 4'd0, 5'd1}) begin
            bad++;
            $display("FAIL restart_write: got we=%b addr=%0d len=%0d, want 1/0/1", mem_we, mem_addr, prog_len);
        end
    endtask
    task automatic test_reset_mid_load;
        do_reset();
        begin_prog();
        beat(7, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            beat(1, i, i, i);
            tick();
        end
        rst = 1;
        tick();
        idle_in();
        total++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, prog_len, busy, done, err_illegal, err_count} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b we=%b addr=%0d data=%h len=%0d busy=%b done=%b err=%b cnt=%0d, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, prog_len, busy, done, err_illegal, err_count);
        end
        rst = 0;
        begin_prog();
        beat(0, 2, 3, 4);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, prog_len, err_count} !== {1'b1, 4'd0, 5'd1, 8'd0}) begin
            bad++;
            $display("FAIL post_reset_write: got we=%b addr=%0d len=%0d cnt=%0d, want 1/0/1/0",
                     mem_we, mem_addr, prog_len, err_count);
        end
    endtask
    task automatic test_saturation;
        do_reset();
        begin_prog();
        beat(7, 1, 1, 1);
        for (int i = 0; i < 260; i++) tick();
        total++;
        if ({mem_we, err_illegal, err_count, prog_len} !== {1'b0, 1'b1, 8'd255, 5'd0}) begin
            bad++;
            $display("FAIL err_saturate: got we=%b err=%b cnt=%0d len=%0d, want 0/1/255/0",
                     mem_we, err_illegal, err_count, prog_len);
        end
        beat(0, 1, 1, 1);
        tick();
        idle_in();
        total++;
        if ({mem_we, mem_addr, err_count} !== {1'b1, 4'd0, 8'd255}) begin
            bad++;
            $display("FAIL sat_then_legal: got we=%b addr=%0d cnt=%0d, want 1/0/255", mem_we, mem_addr, err_count);
        end
    endtask
    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            int ptr, errs;
            ptr = 0;
            errs = 0;
            do_reset();
            begin_prog();
            for (int c = 0; c < 25; c++) begin
                int op, dst, src, opr;
                bit v, rdy, ew, ee;
                logic [15:0] ed;
                int ea;
                op = $urandom_range(7); dst = $urandom_range(7); src = $urandom_range(7);
                opr = $urandom_range(1) ? $urandom_range(7) : $urandom_range(127);
                v = $urandom_range(3) != 0;
                beat(op, dst, src, opr);
                in_valid = v;
                start = $urandom_range(7) == 0;
                rdy = ptr < 15;
                total++;
                if (in_ready !== rdy) begin
                    bad++;
                    $display("FAIL rnd_ready r%0d c%0d: got %b, want %b", r, c, in_ready, rdy);
                end
                ew = v && rdy && exp_legal(op, opr);
                ee = v && rdy && !exp_legal(op, opr);
                ea = ptr;
                ed = exp_word(op, dst, src, opr);
                tick();
                if (ew) ptr++;
                if (ee && errs < 255) errs++;
                total++;
                if ({mem_we, err_illegal, err_count, prog_len} !== {ew, ee, 8'(errs), 5'(ptr)}) begin
                    bad++;
                    $display("FAIL rnd_status r%0d c%0d: got we=%b err=%b cnt=%0d len=%0d, want %b/%b/%0d/%0d",
                             r, c, mem_we, err_illegal, err_count, prog_len, ew, ee, errs, ptr);
                end
                if (ew) begin
                    total++;
                    if ({mem_addr, mem_wdata} !== {4'(ea), ed}) begin
                        bad++;
                        $display("FAIL rnd_write r%0d c%0d: got addr=%0d data=%h, want %0d/%h",
                                 r, c, mem_addr, mem_wdata, ea, ed);
                    end
                end
            end
            idle_in();
            seal = 1;
            tick();
            seal = 0;
            tick();
            total++;
            if ({mem_we, mem_addr, mem_wdata, prog_len} !== {1'b1, 4'(ptr), 16'h8000, 5'(ptr + 1)}) begin
                bad++;
                $display("FAIL rnd_seal r%0d: got we=%b addr=%0d data=%h len=%0d, want 1/%0d/8000/%0d",
                         r, mem_we, mem_addr, mem_wdata, prog_len, ptr, ptr + 1);
            end
            tick();
            total++;
            if (done !== 1'b1) begin
                bad++;
                $display("FAIL rnd_done r%0d: got %b, want 1", r, done);
            end
        end
    endtask
    initial begin
        idle_in();
        test_reset();
        test_encode();
        test_forcing();
        test_illegal();
        test_fill_seal();
        test_back_to_back();
        test_reset_mid_load();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Loader-side counterpart of the instruction decoder. Accepts instruction fields over a valid/ready stream, validates them and packs them into instruction words.
- Writes the words sequentially into program memory and seals the program with a terminating WAIT.
- Sits between the test/boot host and the CPU's instruction memory write port.

Parameters:
OPCODE_WIDTH, 3, opcode field width (fixed by ISA package)
INSTR_WIDTH, 16, instruction word width
ADDR_WIDTH, 4, program memory address width; DEPTH = 2**ADDR_WIDTH words

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin a new program at address 0 (honoured in IDLE and DONE)
seal  input  1  end of program request (honoured in LOAD)
in_valid  input  1  field beat valid
in_ready  output  1  encoder can accept a beat
in_opcode  input  OPCODE_WIDTH  opcode
in_dst  input  3  destination register
in_src  input  3  source register
in_operand  input  7  immediate (ADDI/MULI) or rt in [2:0] (ADD/MUL)
mem_we  output  1  program memory write strobe
mem_addr  output  ADDR_WIDTH  write address
mem_wdata  output  INSTR_WIDTH  encoded word
prog_len  output  ADDR_WIDTH+1  words written, including the seal
busy  output  1  state is LOAD or SEAL
done  output  1  program sealed (level)
err_illegal  output  1  one-cycle pulse per rejected beat
err_count  output  8  saturating count of rejected beats

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs are 0; state is IDLE; write pointer is 0; err_count is 0.
- rst during any state, including mid-LOAD or SEAL, aborts with no further writes. Memory contents are not cleared.
- Word format: [15:13] opcode, [12:10] dst, [9:7] src, [6:0] operand.
- Opcodes: ADD=0, ADDI=1, MUL=2, MULI=3, WAIT=4, LDSW=5. Codes 6 and 7 are illegal.
- Field forcing:
  - WAIT: dst, src and operand are zeroed.
  - LDSW: src and operand are zeroed.
  - ADD/MUL: operand[6:3] must be 0, otherwise the beat is illegal.
  - ADDI/MULI: all fields pass through.
- States:
  - IDLE: in_ready=0. start -> LOAD, pointer cleared, prog_len=0, done=0.
  - LOAD: in_ready = (pointer < DEPTH-1). The last slot is reserved for the seal. seal -> SEAL.
  - SEAL: writes WAIT word 0x8000 at the pointer -> DONE.
  - DONE: done=1, in_ready=0. start -> LOAD as from IDLE.
- Handshake: a transfer occurs when in_valid && in_ready.
- Latency: a beat accepted at cycle N produces mem_we=1 at N+1, with registered mem_addr and mem_wdata. Throughput is one word per cycle.
- Legal beat: the pointer and prog_len increment on the write cycle.
- Illegal beat: it is consumed (no stall) but not written. err_illegal pulses at N+1, err_count increments and saturates at 255, and the pointer is unchanged.
- Seal and beat in the same LOAD cycle: the beat is accepted and written first, then the seal follows with no gap. Example: beat at N gives a write at N+1 and the seal write at N+2; done rises at N+3.
- Seal while the pointer is DEPTH-1 (full): still honoured; the seal occupies address DEPTH-1 and prog_len becomes DEPTH.
- start in LOAD/SEAL and seal outside LOAD are ignored. in_valid outside LOAD is ignored (no ready).
- mem_we is never asserted in IDLE or DONE. mem_addr never wraps.

Decomposition:
- Shared package isa_pkg holds:
  - the opcode enum (ADD..LDSW);
  - OPCODE_WIDTH and INSTR_WIDTH;
  - field bit positions;
  - the WAIT_WORD constant 0x8000.
- The decoder uses the same package.
- One combinational sub-module, instr_pack, performs field forcing, legality check and packing. The FSM, pointer, output register and counters stay in instruction_encoder.

Test Plan:
- Encode: start, then ADD dst=1 src=2 operand=3 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x0503; prog_len=1.
- Immediate and forcing: ADDI dst=2 src=2 imm=0x7F -> 0x297F at addr 0. Then WAIT dst=7 src=5 operand=0x55 -> 0x8000 at addr 1. Then LDSW dst=3 src=4 operand=9 -> 0xAC00 at addr 2.
- Illegal beats: opcode 6, then ADD with operand=0x08 -> no mem_we; err_illegal pulses twice; err_count=2. The next legal beat is written at the unchanged address.
- Fill and seal with ADDR_WIDTH=4: 15 back-to-back legal beats -> in_ready drops after the 15th accept. seal -> 0x8000 at addr 15, done=1, prog_len=16. A further in_valid produces no write.
- Concurrency: seal asserted with an accepted beat at cycle N -> data write at N+1, seal write at N+2, done at N+3. start in DONE restarts at addr 0 with done=0.
- Reset mid-LOAD: rst after 3 writes -> all outputs 0, state IDLE. The next start then writes its first beat at addr 0 with prog_len=1, and err_count is cleared.
